// File: rtl/generic_fifo_pkg.sv
// generic_fifo_pkg
// Shared definitions for the single-clock programmable FIFO:
//   LVL_Q0..LVL_Q3 : encodings of the quarter-fill 'level' output
//   cnt_width(aw)  : width of the occupancy counter for a 2**aw deep FIFO
//                    (one extra bit so that the value D itself is representable)
package generic_fifo_pkg;

  localparam logic [1:0] LVL_Q0 = 2'd0;  // cnt <  D/4
  localparam logic [1:0] LVL_Q1 = 2'd1;  // cnt <  D/2
  localparam logic [1:0] LVL_Q2 = 2'd2;  // cnt <  3D/4
  localparam logic [1:0] LVL_Q3 = 2'd3;  // cnt >= 3D/4

  function automatic int cnt_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/generic_dpram_sc.sv
// generic_dpram_sc
// Single-clock dual-port storage, DW x 2**AW words.
// One registered write port, one asynchronous read port. Contents are never
// initialised or cleared.
// Ports:
//   clk    : clock, write on rising edge
//   we     : write enable
//   waddr  : write address
//   din    : write data
//   raddr  : read address
//   rdata  : read data (combinational from raddr)
module generic_dpram_sc #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] din,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= din;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/generic_fifo_sc_prog.sv
// generic_fifo_sc_prog
// Single-clock FIFO, 2**AW words of DW bits, with programmable almost-full /
// almost-empty thresholds, quarter-fill level, and sticky overflow/underflow.
//
// Handshake: a write is accepted at a rising edge iff we=1 and full=0; a read
// is accepted iff re=1 and empty=0. Requests that are not accepted are simply
// dropped (no retry), but set ovf/udf respectively.
//
// Optional feature macro: GENERIC_FIFO_SC_PROG_FWFT_EN
//   defined   : first-word fall-through, dout shows the head word while !empty
//   undefined : dout is registered, loaded at the edge a read is accepted
//
// Ports:
//   clk, rst (sync, active-low), clr (sync flush, active-high)
//   din/we : write side;  re/dout : read side
//   af_thr, ae_thr : live thresholds compared against registered cnt
//   full, full_n, empty, empty_n, almost_full, almost_empty : status
//   cnt : words held (0..D);  level : quarter-fill indicator
//   ovf, udf : sticky error flags, cleared by rst or clr
module generic_fifo_sc_prog
  import generic_fifo_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic [DW-1:0]           din,
  input  logic                    we,
  input  logic                    re,
  output logic [DW-1:0]           dout,
  input  logic [cnt_width(AW)-1:0] af_thr,
  input  logic [cnt_width(AW)-1:0] ae_thr,
  output logic                    full,
  output logic                    full_n,
  output logic                    empty,
  output logic                    empty_n,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [cnt_width(AW)-1:0] cnt,
  output logic [1:0]              level,
  output logic                    ovf,
  output logic                    udf
);

  localparam int CW = cnt_width(AW);
  localparam int D  = 2**AW;
  localparam logic [CW-1:0] CNT_FULL = CW'(D);
  localparam logic [CW-1:0] CNT_Q1   = CW'(D / 4);
  localparam logic [CW-1:0] CNT_Q2   = CW'(D / 2);
  localparam logic [CW-1:0] CNT_Q3   = CW'((3 * D) / 4);

  logic [AW-1:0] wp, rp;
  logic [DW-1:0] rdata;
  logic          wr_ok, rd_ok, mem_we;
  logic [CW-1:0] cnt_nxt;

  // Acceptance uses the registered flags, so a full FIFO with we=re=1 only
  // reads and an empty FIFO with we=re=1 only writes.
  assign wr_ok  = we & ~full;
  assign rd_ok  = re & ~empty;
  // Reset and flush both suppress the storage write of that cycle.
  assign mem_we = wr_ok & rst & ~clr;

  always_comb begin
    cnt_nxt = cnt;
    case ({wr_ok, rd_ok})
      2'b10:   cnt_nxt = cnt + 1'b1;
      2'b01:   cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else if (clr) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (wr_ok) wp <= wp + 1'b1;
      if (rd_ok) rp <= rp + 1'b1;
      cnt   <= cnt_nxt;
      // Flags are registered from the next count so they line up with cnt.
      full  <= (cnt_nxt == CNT_FULL);
      empty <= (cnt_nxt == '0);
      if (we & full)  ovf <= 1'b1;
      if (re & empty) udf <= 1'b1;
    end
  end

  assign full_n       = ~full;
  assign empty_n      = ~empty;
  assign almost_full  = (cnt >= af_thr);
  assign almost_empty = (cnt <= ae_thr);

  always_comb begin
    if (cnt < CNT_Q1)      level = LVL_Q0;
    else if (cnt < CNT_Q2) level = LVL_Q1;
    else if (cnt < CNT_Q3) level = LVL_Q2;
    else                   level = LVL_Q3;
  end

  generic_dpram_sc #(.DW(DW), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wp),
    .din   (din),
    .raddr (rp),
    .rdata (rdata)
  );

`ifdef GENERIC_FIFO_SC_PROG_FWFT_EN
  // Head word is visible whenever data is held; forcing zero while empty
  // keeps never-written locations off the output.
  assign dout = empty ? '0 : rdata;
`else
  always_ff @(posedge clk) begin
    if (!rst)                dout <= '0;
    else if (!clr && rd_ok)  dout <= rdata;
  end
`endif

endmodule

// File: doc/generic_fifo_sc_prog.md
GENERIC_FIFO_SC_PROG -- requirements
Module: generic_fifo_sc_prog

Interface
REQ-001 SHALL have parameter DW, default 8, data width in bits.
REQ-002 SHALL have parameter AW, default 4, address width; depth D = 2**AW words.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset; one clock, reset is synchronous and active-low.
REQ-005 clr  in  1  synchronous flush, active-high.
REQ-006 din  in  DW  write data; we  in  1  write request.
REQ-007 re  in  1  read request; dout  out  DW  read data.
REQ-008 af_thr  in  AW+1  almost-full threshold; ae_thr  in  AW+1  almost-empty threshold.
REQ-009 full, full_n, empty, empty_n  out  1 each  status flags plus complements.
REQ-010 almost_full, almost_empty  out  1 each  threshold flags.
REQ-011 cnt  out  AW+1  words held, 0..D; level  out  2  quarter-fill indicator.
REQ-012 ovf, udf  out  1 each  sticky overflow and underflow error flags.

Function
REQ-013 Write accepted at an edge iff we=1 and full=0 at that edge; din stored at write pointer, pointer += 1 mod D.
REQ-014 Read accepted at an edge iff re=1 and empty=0 at that edge; read pointer += 1 mod D.
REQ-015 Accepted write and read in the same cycle: cnt unchanged, both pointers advance.
REQ-016 Full with we=re=1: only the read is accepted, cnt becomes D-1. Empty with we=re=1: only the write is accepted, cnt becomes 1.
REQ-017 we=1 while full sets ovf. re=1 while empty sets udf. Both stay set until rst or clr.
REQ-018 Pointers are AW bits and wrap from D-1 to 0 with no bubble. cnt is AW+1 bits and never exceeds D.
REQ-019 full = (cnt==D); empty = (cnt==0); full_n = !full; empty_n = !empty. All are registered and valid in the cycle after the edge that changed cnt.
REQ-020 almost_full = (cnt >= af_thr); almost_empty = (cnt <= ae_thr). Both compare registered cnt against the live threshold inputs.
REQ-021 level: 0 if cnt < D/4; 1 if cnt < D/2; 2 if cnt < 3D/4; 3 otherwise.
REQ-022 clr=1 empties the FIFO in one cycle: pointers, cnt, ovf and udf go to 0, and we/re in that cycle are ignored. dout is not changed by clr.
REQ-023 Memory contents are not cleared by rst or clr; a location is never read before it has been written.

Reset
REQ-024 rst=0 at an edge SHALL set pointers=0, cnt=0, empty=1, empty_n=0, full=0, full_n=1, almost_empty=(ae_thr>=0)=1, level=0, ovf=0, udf=0, dout=0.
REQ-025 rst has priority over clr, and clr has priority over we/re. A reset asserted mid-transfer discards all stored words.

Configuration
REQ-026 Macro GENERIC_FIFO_SC_PROG_FWFT_EN SHALL select the read mode.
- Defined (first-word fall-through): dout presents the head word combinationally whenever empty=0; an accepted read pops it, and the next word appears in the same cycle as the pointer update.
- Undefined: dout is registered; it is loaded with the head word at the edge a read is accepted, so data is valid one cycle after re; dout holds otherwise.

Structure
REQ-027 Shared package generic_fifo_pkg SHALL hold the level encoding constants (LVL_Q0..LVL_Q3) and the function computing cnt width from AW.
REQ-028 Storage SHALL be a sub-module generic_dpram_sc: one write port, one read port, registered write, asynchronous read, DW x D.

Verification (DW=8, AW=4, D=16, af_thr=12, ae_thr=3)
REQ-029 Reset then write 0x01..0x10 one per cycle -> cnt=16, full=1; almost_full asserts after write 12; level goes 0,1,2,3 at cnt 4, 8, 12.
REQ-030 17th write with we=1 while full -> write ignored, ovf=1, cnt stays 16. Read all 16 -> data 0x01..0x10 in order (registered mode: one cycle after each re); empty=1.
REQ-031 re=1 while empty -> udf=1, cnt=0, dout unchanged. clr=1 -> ovf=0, udf=0.
REQ-032 Hold cnt=8, drive we=re=1 for 40 cycles with random din -> cnt stays 8, pointers wrap twice, scoreboard matches every word; repeat at cnt=16 and cnt=0 to check REQ-016.
REQ-033 Fill with 10 words, then pulse clr together with we=1 -> next cycle cnt=0, empty=1, and the word written in that cycle is lost. Pulse rst=0 at cnt=5 -> all REQ-024 values next cycle.
REQ-034 Repeat REQ-029 and REQ-030 with GENERIC_FIFO_SC_PROG_FWFT_EN defined -> dout=0x01 in the cycle after the first write, with zero read latency.
